// File: rtl/ff_pkg.sv
// ff_pkg: shared GF(2^8) field types, constants and divider state encoding
package ff_pkg;

    localparam int       FF_NUM_BITS = 8;
    localparam logic [8:0] FF_POLY   = 9'h11B;

    typedef logic [FF_NUM_BITS-1:0] ff_elem_t;

    typedef enum logic [1:0] {
        IDLE,
        SQMUL,
        FINAL
    } ff_div_state_t;

endpackage

// File: rtl/ff_mult.sv
// ff_mult: combinational GF(2^NUM_BITS) multiplier reduced modulo POLY
// Ports:
//   i_a, i_b : field element operands
//   o_p      : product i_a * i_b mod POLY
module ff_mult
    import ff_pkg::*;
#(
    parameter int         NUM_BITS = FF_NUM_BITS,
    parameter logic [8:0] POLY     = FF_POLY
) (
    input  logic [NUM_BITS-1:0] i_a,
    input  logic [NUM_BITS-1:0] i_b,
    output logic [NUM_BITS-1:0] o_p
);

    logic [NUM_BITS-1:0] w_p;
    logic [NUM_BITS-1:0] w_x;

    // Shift-and-add: w_x walks i_a * x^k, reduced each step so it stays in the field.
    always_comb begin
        w_p = '0;
        w_x = i_a;
        for (int k = 0; k < NUM_BITS; k++) begin
            w_p = i_b[k] ? (w_p ^ w_x) : w_p;
            w_x = {w_x[NUM_BITS-2:0], 1'b0} ^ (w_x[NUM_BITS-1] ? POLY[NUM_BITS-1:0] : '0);
        end
    end

    assign o_p = w_p;

endmodule

// File: rtl/ff_div.sv
// ff_div: sequential GF(2^8) divider, quotient = dividend * divisor^254
// Ports:
//   i_clk, i_n_rst (sync active-low), i_start, i_dividend, i_divisor
//   o_busy, o_done (1-cycle pulse), o_quotient, o_div_by_zero
// Optional macro FF_DIV_ZERO_CHECK_EN: zero divisor returns in one cycle with o_div_by_zero=1.
module ff_div
    import ff_pkg::*;
#(
    parameter int         NUM_BITS = FF_NUM_BITS,
    parameter logic [8:0] POLY     = FF_POLY
) (
    input  logic                i_clk,
    input  logic                i_n_rst,
    input  logic                i_start,
    input  logic [NUM_BITS-1:0] i_dividend,
    input  logic [NUM_BITS-1:0] i_divisor,
    output logic                o_busy,
    output logic                o_done,
    output logic [NUM_BITS-1:0] o_quotient,
    output logic                o_div_by_zero
);

    localparam int CNT_W = $clog2(NUM_BITS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_BITS - 2);

    ff_div_state_t       r_state;
    ff_div_state_t       w_state_n;
    logic [NUM_BITS-1:0] r_a;
    logic [NUM_BITS-1:0] r_sq;
    logic [NUM_BITS-1:0] r_acc;
    logic [CNT_W-1:0]    r_cnt;
    logic [NUM_BITS-1:0] r_quot;
    logic                r_busy;
    logic                r_done;
    logic [NUM_BITS-1:0] w_sq2;
    logic [NUM_BITS-1:0] w_acc_n;
    logic [NUM_BITS-1:0] w_q;
    logic                w_zero;

`ifdef FF_DIV_ZERO_CHECK_EN
    logic r_dbz;
    assign w_zero        = (i_divisor == '0);
    assign o_div_by_zero = r_dbz;
`else
    assign w_zero        = 1'b0;
    assign o_div_by_zero = 1'b0;
`endif

    // The fresh square feeds the accumulate multiply in the same cycle.
    ff_mult #(.NUM_BITS(NUM_BITS), .POLY(POLY)) u_sq  (.i_a(r_sq),  .i_b(r_sq),  .o_p(w_sq2));
    ff_mult #(.NUM_BITS(NUM_BITS), .POLY(POLY)) u_acc (.i_a(r_acc), .i_b(w_sq2), .o_p(w_acc_n));
    ff_mult #(.NUM_BITS(NUM_BITS), .POLY(POLY)) u_fin (.i_a(r_a),   .i_b(r_acc), .o_p(w_q));

    always_ff @(posedge i_clk) begin
        if (!i_n_rst) r_state <= IDLE;
        else          r_state <= w_state_n;
    end

    always_comb begin
        w_state_n = IDLE;
        case (r_state)
            IDLE:    w_state_n = (i_start && !w_zero) ? SQMUL : IDLE;
            SQMUL:   w_state_n = (r_cnt == CNT_LAST) ? FINAL : SQMUL;
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_n_rst) begin
            r_a    <= '0;
            r_sq   <= '0;
            r_acc  <= NUM_BITS'(1);
            r_cnt  <= '0;
            r_quot <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
`ifdef FF_DIV_ZERO_CHECK_EN
            r_dbz  <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (i_start && w_zero) begin
                        r_quot <= '0;
                        r_done <= 1'b1;
`ifdef FF_DIV_ZERO_CHECK_EN
                        r_dbz  <= 1'b1;
`endif
                    end else if (i_start) begin
                        r_a    <= i_dividend;
                        r_sq   <= i_divisor;
                        r_acc  <= NUM_BITS'(1);
                        r_cnt  <= '0;
                        r_busy <= 1'b1;
                    end
                end
                SQMUL: begin
                    r_sq  <= w_sq2;
                    r_acc <= w_acc_n;
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                FINAL: begin
                    r_quot <= w_q;
                    r_done <= 1'b1;
                    r_busy <= 1'b0;
`ifdef FF_DIV_ZERO_CHECK_EN
                    r_dbz  <= 1'b0;
`endif
                end
                default: r_busy <= 1'b0;
            endcase
        end
    end

    assign o_busy     = r_busy;
    assign o_done     = r_done;
    assign o_quotient = r_quot;

endmodule
